div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider that serves the ALU core's DIV/DIVU/REM/REMU requests.
- The ALU core drives dividend, divisor and start, and holds start high while it is stalled.
- This block returns a one-cycle result-ready pulse with the 32-bit quotient or remainder.
- It sits beside the ALU core in the execute stage. The decode/execute pipeline supplies the op select and the flush.

---
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU; optional early-out via DIV_FAST_PATH_EN
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start_i,
    input  logic [1:0]            div_op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  div_flush_i,
    output logic                  div_res_ready_o,
    output logic [DATA_WIDTH-1:0] div_result_o,
    output logic                  div_busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] quo, rem, dvs, result;
    logic                  rem_sel, neg_quo, neg_rem, div_zero;

    logic                  in_signed, a_neg, b_neg, accept, fast, last_iter, load_result;
    logic [DATA_WIDTH-1:0] a_abs, b_abs, fast_result, result_nxt;
    logic [DATA_WIDTH:0]   shifted;
    logic                  fits;
    logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

    // Sign restoration on the magnitudes; a zero divisor forces an all-ones quotient.
    function automatic logic [DATA_WIDTH-1:0] fixup(
        input logic [DATA_WIDTH-1:0] q_abs,
        input logic [DATA_WIDTH-1:0] r_abs,
        input logic                  sel_rem,
        input logic                  nq,
        input logic                  nr,
        input logic                  dz
    );
        logic [DATA_WIDTH-1:0] q, r;
        q = dz ? '1 : (nq ? -q_abs : q_abs);
        r = nr ? -r_abs : r_abs;
        return sel_rem ? r : q;
    endfunction

    assign in_signed = ~div_op_i[0];
    assign a_neg     = in_signed & dividend_i[DATA_WIDTH-1];
    assign b_neg     = in_signed & divisor_i[DATA_WIDTH-1];
    assign a_abs     = a_neg ? -dividend_i : dividend_i;
    assign b_abs     = b_neg ? -divisor_i : divisor_i;
    assign accept    = (state == IDLE) && div_start_i && !div_flush_i;

`ifdef DIV_FAST_PATH_EN
    logic in_zero, in_ovf, in_small;
    assign in_zero  = (divisor_i == '0);
    assign in_ovf   = in_signed && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (divisor_i == '1);
    assign in_small = (a_abs < b_abs);
    assign fast     = in_zero | in_ovf | in_small;
    // Overflow magnitude is |MIN| / 1, so the quotient magnitude is the dividend magnitude itself.
    assign fast_result = fixup(in_zero ? '1 : (in_ovf ? a_abs : '0),
                               in_ovf ? '0 : a_abs,
                               div_op_i[1], a_neg ^ b_neg, a_neg, in_zero);
`else
    assign fast        = 1'b0;
    assign fast_result = '0;
`endif

    // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
    assign shifted = {rem, quo[DATA_WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs});
    assign rem_nxt = fits ? (shifted[DATA_WIDTH-1:0] - dvs) : shifted[DATA_WIDTH-1:0];
    assign quo_nxt = {quo[DATA_WIDTH-2:0], fits};

    assign last_iter   = (state == CALC) && (&cnt);
    assign load_result = !div_flush_i && (last_iter || (accept && fast));
    assign result_nxt  = (state == IDLE) ? fast_result
                                         : fixup(quo_nxt, rem_nxt, rem_sel, neg_quo, neg_rem, div_zero);

    always_comb begin
        state_nxt = state;
        if (div_flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (div_start_i) state_nxt = fast ? DONE : CALC;
                CALC:    if (&cnt) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            result   <= '0;
            rem_sel  <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem_sel  <= div_op_i[1];
                neg_quo  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (divisor_i == '0);
                dvs      <= b_abs;
                quo      <= a_abs;
                rem      <= '0;
                cnt      <= '0;
            end else if (state == CALC) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt + 1'b1;
            end
            if (load_result) result <= result_nxt;
        end
    end

    assign div_res_ready_o = (state == DONE) && !div_flush_i;
    assign div_busy_o      = (state != IDLE);
    assign div_result_o    = result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against a RISC-V M division model
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (start),
        .div_op_i        (op),
        .dividend_i      (a),
        .divisor_i       (b),
        .div_flush_i     (flush),
        .div_res_ready_o (ready),
        .div_result_o    (result),
        .div_busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic longint ext(input logic [1:0] f, input logic [31:0] x);
        if (f[0]) return longint'({32'b0, x});
        return longint'({{32{x[31]}}, x});
    endfunction

    // RISC-V M semantics with 64-bit arithmetic; truncation toward zero matches the ISA.
    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = ext(f, x);
        sy = ext(f, y);
        if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
        q = sx / sy;
        r = sx % sy;
        return f[1] ? r[31:0] : q[31:0];
    endfunction

    // Edge index (after accept edge E0) whose following cycle carries the ready pulse.
    function automatic int ref_edge(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ax, ay;
        sx = ext(f, x);
        sy = ext(f, y);
        ax = (sx < 0) ? -sx : sx;
        ay = (sy < 0) ? -sy : sy;
        if (FAST && ((y == 32'd0) || (ax < ay) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 0;
        return 32;
    endfunction

    task automatic run_op(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int edge_k, output int n_ready, output bit busy_ok);
        @(negedge clk);
        op = f; a = x; b = y; start = 1'b1;
        res = '0; edge_k = -1; n_ready = 0; busy_ok = 1'b1;
        for (int k = 0; k < 40 && edge_k < 0; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ready === 1'b1) begin
                edge_k = k; n_ready++; res = result; start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        if (ready === 1'b1) n_ready++;
    endtask

    task automatic test_reset();
        logic [31:0] res; int ek, nr; bit bo;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if ({ready, busy, result} !== 34'd0) $display("FAIL reset_state: got %h want 0", {ready, busy, result}); else n_pass++;
        rst = 1'b0;
        run_op(OP_DIVU, 32'd100, 32'd7, res, ek, nr, bo);
        n_checks++; if (res !== 32'd14) $display("FAIL reset_pre_result: got %h want %h", res, 32'd14); else n_pass++;
        @(negedge clk);
        op = OP_DIVU; a = 32'd50; b = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_midcalc_busy: got %b want 1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({ready, busy, result} !== 34'd0) $display("FAIL reset_async_clear: got %h want 0", {ready, busy, result}); else n_pass++;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_DIVU, 32'd100, 32'd7, res, ek, nr, bo);
        n_checks++; if (res !== 32'd14) $display("FAIL reset_post_result: got %h want %h", res, 32'd14); else n_pass++;
        n_checks++; if (ek !== 32) $display("FAIL reset_post_latency: got %0d want 32", ek); else n_pass++;
        n_checks++; if (nr !== 1) $display("FAIL reset_post_ready_count: got %0d want 1", nr); else n_pass++;
    endtask

    task automatic test_signed();
        logic [1:0]  ops [3] = '{OP_DIV, OP_REM, OP_REMU};
        logic [31:0] xs  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] res; int ek, nr; bit bo;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], 32'd2, res, ek, nr, bo);
            n_checks++; if (res !== exp[i]) $display("FAIL signed_%0d_result: got %h want %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (nr !== 1) $display("FAIL signed_%0d_ready_count: got %0d want 1", i, nr); else n_pass++;
            n_checks++; if (!bo) $display("FAIL signed_%0d_busy: got 0 want 1 throughout", i); else n_pass++;
            n_checks++; if (ek !== 32) $display("FAIL signed_%0d_latency: got %0d want 32", i, ek); else n_pass++;
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] xs  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd3, 32'd3};
        logic [31:0] ys  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'd10};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'd3};
        logic [31:0] res; int ek, nr; bit bo;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], xs[i], ys[i], res, ek, nr, bo);
            n_checks++; if (res !== exp[i]) $display("FAIL special_%0d_result: got %h want %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (ek !== (FAST ? 0 : 32)) $display("FAIL special_%0d_latency: got %0d want %0d", i, ek, FAST ? 0 : 32); else n_pass++;
            n_checks++; if (nr !== 1) $display("FAIL special_%0d_ready_count: got %0d want 1", i, nr); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int nr = 0, k1 = -1, k2 = -1;
        logic [31:0] r1 = '0, r2 = '0;
        @(negedge clk);
        op = OP_DIVU; a = 32'd77; b = 32'd7; start = 1'b1;
        for (int k = 0; k < 76; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                nr++;
                if (k1 < 0) begin
                    k1 = k; r1 = result;
                    op = OP_DIV; a = 32'd1000; b = 32'hFFFF_FFF6;
                end else begin
                    k2 = k; r2 = result; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (r1 !== 32'd11) $display("FAIL b2b_first_result: got %h want %h", r1, 32'd11); else n_pass++;
        n_checks++; if (r2 !== 32'hFFFF_FF9C) $display("FAIL b2b_second_result: got %h want %h", r2, 32'hFFFF_FF9C); else n_pass++;
        n_checks++; if (nr !== 2) $display("FAIL b2b_ready_count: got %0d want 2", nr); else n_pass++;
        n_checks++; if (k1 !== 32) $display("FAIL b2b_first_latency: got %0d want 32", k1); else n_pass++;
        n_checks++; if (k2 !== 66) $display("FAIL b2b_second_latency: got %0d want 66", k2); else n_pass++;
    endtask

    task automatic test_flush();
        int pre_ready = 0, nr = 0, ek = -1;
        logic [31:0] res = '0;
        @(negedge clk);
        op = OP_DIVU; a = 32'd123; b = 32'd4; start = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (ready === 1'b1) pre_ready++;
        end
        flush = 1'b1;
        @(negedge clk);
        if (ready === 1'b1) pre_ready++;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_idle: got busy %b want 0", busy); else n_pass++;
        flush = 1'b0; a = 32'd50; b = 32'd5;
        for (int k = 0; k < 40 && ek < 0; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin ek = k; nr++; res = result; start = 1'b0; end
        end
        start = 1'b0;
        @(negedge clk);
        if (ready === 1'b1) nr++;
        n_checks++; if (pre_ready !== 0) $display("FAIL flush_no_ready: got %0d pulses want 0", pre_ready); else n_pass++;
        n_checks++; if (res !== 32'd10) $display("FAIL flush_next_result: got %h want %h", res, 32'd10); else n_pass++;
        n_checks++; if (ek !== 32) $display("FAIL flush_next_latency: got %0d want 32", ek); else n_pass++;
        n_checks++; if (nr !== 1) $display("FAIL flush_next_ready_count: got %0d want 1", nr); else n_pass++;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0] f; logic [31:0] x, y, res, exp; int ek, nr, exp_k; bit bo;
        for (int i = 0; i < 1200; i++) begin
            f = 2'($urandom_range(0, 3)); x = pick(); y = pick();
            exp = ref_result(f, x, y);
            exp_k = ref_edge(f, x, y);
            run_op(f, x, y, res, ek, nr, bo);
            n_checks++; if (res !== exp) $display("FAIL random_result op=%0d %h/%h: got %h want %h", f, x, y, res, exp); else n_pass++;
            n_checks++; if (ek !== exp_k) $display("FAIL random_latency op=%0d %h/%h: got %0d want %0d", f, x, y, ek, exp_k); else n_pass++;
            n_checks++; if (nr !== 1) $display("FAIL random_ready_count op=%0d %h/%h: got %0d want 1", f, x, y, nr); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
